// File: rtl/window_sched.sv
// Sliding-window scheduler: steps a WIN_W x WIN_H window across the screen,
// one position per frame, handshaking with the window buffer and mult-adder tree.
module window_sched #(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned WIN_W    = 28,
    parameter int unsigned WIN_H    = 28,
    parameter int unsigned STRIDE_X = 14,
    parameter int unsigned STRIDE_Y = 14,
    parameter int unsigned POS_BITS = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                continuous,
    input  logic                frame_start,
    input  logic                buffer_rdy,
    input  logic                compute_done,
    output logic [POS_BITS-1:0] buffer_x_pos,
    output logic [POS_BITS-1:0] buffer_y_pos,
    output logic                compute_start,
    output logic                busy,
    output logic                sweep_done,
    output logic [15:0]         win_count
);

    localparam int unsigned CW    = POS_BITS + 2;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        WAIT_RDY,
        COMPUTE,
        ADVANCE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [POS_BITS-1:0] x_nx;
    logic [POS_BITS-1:0] y_nx;
    logic [CNT_W-1:0]    count_nx;
    logic                cs_nx;
    logic                sd_nx;
    logic [CW-1:0]       x_end;
    logic [CW-1:0]       y_end;
    logic                x_fits;
    logic                y_fits;

    // Far edge of the next window, widened so the sum cannot wrap.
    assign x_end  = CW'(buffer_x_pos) + CW'(STRIDE_X) + CW'(WIN_W);
    assign y_end  = CW'(buffer_y_pos) + CW'(STRIDE_Y) + CW'(WIN_H);
    assign x_fits = (x_end <= CW'(SCREEN_W));
    assign y_fits = (y_end <= CW'(SCREEN_H));

    // Next-state and next-output logic.
    always_comb begin
        state_nx = state;
        x_nx     = buffer_x_pos;
        y_nx     = buffer_y_pos;
        count_nx = win_count;
        cs_nx    = 1'b0;
        sd_nx    = 1'b0;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_nx     = '0;
                        y_nx     = '0;
                        count_nx = '0;
                        state_nx = WAIT_FRAME;
                    end
                end
                // buffer_rdy here belongs to the previous position and is dropped.
                WAIT_FRAME: begin
                    if (frame_start) state_nx = WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (buffer_rdy) begin
                        cs_nx    = 1'b1;
                        state_nx = COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (compute_done) state_nx = ADVANCE;
                end
                ADVANCE: begin
                    state_nx = WAIT_FRAME;
                    if (win_count != {CNT_W{1'b1}}) count_nx = win_count + CNT_W'(1);
                    if (x_fits) begin
                        x_nx = buffer_x_pos + POS_BITS'(STRIDE_X);
                    end else begin
                        x_nx = '0;
                        if (y_fits) begin
                            y_nx = buffer_y_pos + POS_BITS'(STRIDE_Y);
                        end else begin
                            y_nx  = '0;
                            sd_nx = 1'b1;
                            if (continuous) count_nx = '0;
                            else            state_nx = IDLE;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            buffer_x_pos  <= '0;
            buffer_y_pos  <= '0;
            win_count     <= '0;
            compute_start <= 1'b0;
            busy          <= 1'b0;
            sweep_done    <= 1'b0;
        end else begin
            state         <= state_nx;
            buffer_x_pos  <= x_nx;
            buffer_y_pos  <= y_nx;
            win_count     <= count_nx;
            compute_start <= cs_nx;
            busy          <= (state_nx != IDLE);
            sweep_done    <= sd_nx;
        end
    end

endmodule

// File: tb/tb_window_sched.sv
// Self-checking bench for window_sched on a 64x48 screen with 28x28 windows, stride 14.
module tb_window_sched;

    localparam int unsigned PB = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          continuous = 1'b0;
    logic          frame_start = 1'b0;
    logic          buffer_rdy = 1'b0;
    logic          compute_done = 1'b0;
    logic [PB-1:0] buffer_x_pos;
    logic [PB-1:0] buffer_y_pos;
    logic          compute_start;
    logic          busy;
    logic          sweep_done;
    logic [15:0]   win_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [2*PB-1:0] exp_q[$];

    int xs[7] = '{0, 14, 28, 0, 14, 28, 0};
    int ys[7] = '{0, 0, 0, 14, 14, 14, 0};

    window_sched #(
        .SCREEN_W(64), .SCREEN_H(48), .WIN_W(28), .WIN_H(28),
        .STRIDE_X(14), .STRIDE_Y(14), .POS_BITS(PB)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .continuous(continuous), .frame_start(frame_start),
        .buffer_rdy(buffer_rdy), .compute_done(compute_done),
        .buffer_x_pos(buffer_x_pos), .buffer_y_pos(buffer_y_pos),
        .compute_start(compute_start), .busy(busy),
        .sweep_done(sweep_done), .win_count(win_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Every compute_start must match a position the bench has scheduled.
    always @(negedge clock) begin
        if (compute_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("cs_unexpected", 32'd1, 32'd0);
            end else begin
                logic [2*PB-1:0] e;
                e = exp_q.pop_front();
                check("cs_pos", 32'({buffer_x_pos, buffer_y_pos}), 32'(e));
            end
        end
    end

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic cyc(input logic s, input logic a, input logic fs, input logic br, input logic cd);
        start = s; abort = a; frame_start = fs; buffer_rdy = br; compute_done = cd;
        @(posedge clock);
        #1;
        start = 1'b0; abort = 1'b0; frame_start = 1'b0; buffer_rdy = 1'b0; compute_done = 1'b0;
    endtask

    task automatic run_window(input int ex, input int ey);
        cyc(0, 0, 1, 0, 0);
        exp_q.push_back({PB'(ex), PB'(ey)});
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, "_x"}, 32'(buffer_x_pos), 32'(ex));
        check({tag, "_y"}, 32'(buffer_y_pos), 32'(ey));
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cs", 32'(compute_start), 0);
        check("rst_sd", 32'(sweep_done), 0);
        check("rst_cnt", 32'(win_count), 0);
        check_pos("rst", 0, 0);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // Full single sweep
        continuous = 1'b0;
        cyc(1, 0, 0, 0, 0);
        check("start_busy", 32'(busy), 1);
        check_pos("start", 0, 0);
        for (int i = 0; i < 6; i++) begin
            run_window(xs[i], ys[i]);
            check_pos("adv", xs[i+1], ys[i+1]);
            check("adv_cnt", 32'(win_count), 32'(i + 1));
            check("adv_sd", 32'(sweep_done), (i == 5) ? 32'd1 : 32'd0);
            check("adv_busy", 32'(busy), (i == 5) ? 32'd0 : 32'd1);
        end
        cyc(0, 0, 0, 0, 0);
        check("sd_pulse_end", 32'(sweep_done), 0);
        check("sweep1_q", 32'(exp_q.size()), 0);

        // Stale buffer_rdy in WAIT_FRAME
        cyc(1, 0, 0, 0, 0);
        check("restart_cnt", 32'(win_count), 0);
        cyc(0, 0, 0, 1, 0);
        check("stale_cs", 32'(compute_start), 0);
        cyc(0, 0, 1, 0, 0);
        check("wr_cs", 32'(compute_start), 0);
        exp_q.push_back({PB'(0), PB'(0)});
        cyc(0, 0, 0, 1, 0);
        check("rdy_cs", 32'(compute_start), 1);
        cyc(0, 0, 0, 0, 1);
        check("cs_one_cycle", 32'(compute_start), 0);
        cyc(0, 0, 0, 0, 0);
        check_pos("stale_adv", 14, 0);

        // Repeated frame_start in WAIT_RDY, start ignored while busy
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check_pos("fs_hold", 14, 0);
        check("fs_cs", 32'(compute_start), 0);
        check("fs_cnt", 32'(win_count), 1);

        // Abort during COMPUTE at (14,0)
        exp_q.push_back({PB'(14), PB'(0)});
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        check("abort_busy", 32'(busy), 0);
        check_pos("abort", 14, 0);
        check("abort_cnt", 32'(win_count), 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        check("abort_cd_busy", 32'(busy), 0);
        check("abort_cd_sd", 32'(sweep_done), 0);
        check_pos("abort_cd", 14, 0);

        // Continuous sweep
        continuous = 1'b1;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) run_window(xs[i], ys[i]);
        check("cont_sd", 32'(sweep_done), 1);
        check("cont_busy", 32'(busy), 1);
        check("cont_cnt", 32'(win_count), 0);
        check_pos("cont", 0, 0);
        run_window(0, 0);
        check_pos("cont_next", 14, 0);
        check("cont_next_cnt", 32'(win_count), 1);
        continuous = 1'b0;
        cyc(0, 1, 0, 0, 0);
        check("cont_abort_busy", 32'(busy), 0);

        // Reset in WAIT_RDY at (28,14) with buffer_rdy
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) run_window(xs[i], ys[i]);
        cyc(0, 0, 1, 0, 0);
        check_pos("pre_rst", 28, 14);
        reset = 1'b0;
        cyc(0, 0, 0, 1, 0);
        reset = 1'b1;
        check("mid_rst_cs", 32'(compute_start), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_cnt", 32'(win_count), 0);
        check("mid_rst_sd", 32'(sweep_done), 0);
        check_pos("mid_rst", 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        check("post_rst_busy", 32'(busy), 0);
        check("final_q", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
